axi_mem_arbiter: RTL and testbench

- Two-master to one-slave AXI4 arbiter that shares the core's single memory bus.
- Master 0 (m0) is the icache refill/direct-fetch port. Master 1 (m1) is the LSU/dcache port. The slave port (s) goes to the SoC crossbar.
- Read and write paths are arbitrated independently, each with its own round-robin pointer.
- A grant is held for the whole burst: until the last R beat on reads, and until the B handshake on writes.

---
 rtl/axi_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter for the core's shared memory bus.
// Read and write paths are arbitrated independently. Each path has its own
// round-robin pointer, and a grant is held for the whole burst.
module axi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    // master 0: icache refill / direct fetch
    input  logic                      m0_arvalid,
    input  logic [ADDR_WIDTH-1:0]     m0_araddr,
    input  logic [ID_WIDTH-1:0]       m0_arid,
    input  logic [7:0]                m0_arlen,
    input  logic [2:0]                m0_arsize,
    input  logic [1:0]                m0_arburst,
    output logic                      m0_arready,
    output logic                      m0_rvalid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic [1:0]                m0_rresp,
    output logic                      m0_rlast,
    output logic [ID_WIDTH-1:0]       m0_rid,
    input  logic                      m0_rready,
    input  logic                      m0_awvalid,
    input  logic [ADDR_WIDTH-1:0]     m0_awaddr,
    input  logic [ID_WIDTH-1:0]       m0_awid,
    input  logic [7:0]                m0_awlen,
    input  logic [2:0]                m0_awsize,
    input  logic [1:0]                m0_awburst,
    output logic                      m0_awready,
    input  logic                      m0_wvalid,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
    input  logic                      m0_wlast,
    output logic                      m0_wready,
    output logic                      m0_bvalid,
    output logic [1:0]                m0_bresp,
    output logic [ID_WIDTH-1:0]       m0_bid,
    input  logic                      m0_bready,
    // master 1: LSU / dcache
    input  logic                      m1_arvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_araddr,
    input  logic [ID_WIDTH-1:0]       m1_arid,
    input  logic [7:0]                m1_arlen,
    input  logic [2:0]                m1_arsize,
    input  logic [1:0]                m1_arburst,
    output logic                      m1_arready,
    output logic                      m1_rvalid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic [1:0]                m1_rresp,
    output logic                      m1_rlast,
    output logic [ID_WIDTH-1:0]       m1_rid,
    input  logic                      m1_rready,
    input  logic                      m1_awvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_awaddr,
    input  logic [ID_WIDTH-1:0]       m1_awid,
    input  logic [7:0]                m1_awlen,
    input  logic [2:0]                m1_awsize,
    input  logic [1:0]                m1_awburst,
    output logic                      m1_awready,
    input  logic                      m1_wvalid,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
    input  logic                      m1_wlast,
    output logic                      m1_wready,
    output logic                      m1_bvalid,
    output logic [1:0]                m1_bresp,
    output logic [ID_WIDTH-1:0]       m1_bid,
    input  logic                      m1_bready,
    // slave port to the SoC crossbar
    output logic                      s_arvalid,
    output logic [ADDR_WIDTH-1:0]     s_araddr,
    output logic [ID_WIDTH-1:0]       s_arid,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    input  logic                      s_arready,
    input  logic                      s_rvalid,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic [ID_WIDTH-1:0]       s_rid,
    output logic                      s_rready,
    output logic                      s_awvalid,
    output logic [ADDR_WIDTH-1:0]     s_awaddr,
    output logic [ID_WIDTH-1:0]       s_awid,
    output logic [7:0]                s_awlen,
    output logic [2:0]                s_awsize,
    output logic [1:0]                s_awburst,
    input  logic                      s_awready,
    output logic                      s_wvalid,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_wlast,
    input  logic                      s_wready,
    input  logic                      s_bvalid,
    input  logic [1:0]                s_bresp,
    input  logic [ID_WIDTH-1:0]       s_bid,
    output logic                      s_bready,
    // status
    output logic                      rd_busy,
    output logic                      wr_busy
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t rd_state, rd_state_nxt;
    wr_state_t wr_state, wr_state_nxt;
    logic      rgnt, rgnt_nxt, rd_rr, rd_rr_nxt;
    logic      wgnt, wgnt_nxt, wr_rr, wr_rr_nxt;

    // Handshake-relevant signals of the currently granted master
    logic sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    assign sel_arvalid = rgnt ? m1_arvalid : m0_arvalid;
    assign sel_rready  = rgnt ? m1_rready  : m0_rready;
    assign sel_awvalid = wgnt ? m1_awvalid : m0_awvalid;
    assign sel_wvalid  = wgnt ? m1_wvalid  : m0_wvalid;
    assign sel_wlast   = wgnt ? m1_wlast   : m0_wlast;
    assign sel_bready  = wgnt ? m1_bready  : m0_bready;

    assign rd_busy = (rd_state != R_IDLE);
    assign wr_busy = (wr_state != W_IDLE);

    // Read-path state, grant and round-robin pointer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rgnt     <= 1'b0;
            rd_rr    <= 1'b1;
        end else begin
            rd_state <= rd_state_nxt;
            rgnt     <= rgnt_nxt;
            rd_rr    <= rd_rr_nxt;
        end
    end

    // Read-path arbitration, next state and AR/R channel routing
    always_comb begin
        rd_state_nxt = rd_state;
        rgnt_nxt     = rgnt;
        rd_rr_nxt    = rd_rr;
        s_arvalid    = '0;
        s_araddr     = '0;
        s_arid       = '0;
        s_arlen      = '0;
        s_arsize     = '0;
        s_arburst    = '0;
        s_rready     = '0;
        m0_arready   = '0;
        m1_arready   = '0;
        m0_rvalid    = '0;
        m0_rdata     = '0;
        m0_rresp     = '0;
        m0_rlast     = '0;
        m0_rid       = '0;
        m1_rvalid    = '0;
        m1_rdata     = '0;
        m1_rresp     = '0;
        m1_rlast     = '0;
        m1_rid       = '0;
        case (rd_state)
            R_IDLE: begin
                // the pointer only moves on a tie, so a lone requester does not disturb fairness
                if (m0_arvalid && m1_arvalid) begin
                    rgnt_nxt     = ~rd_rr;
                    rd_rr_nxt    = ~rd_rr;
                    rd_state_nxt = R_ADDR;
                end else if (m0_arvalid || m1_arvalid) begin
                    rgnt_nxt     = m1_arvalid;
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid = sel_arvalid;
                s_araddr  = rgnt ? m1_araddr  : m0_araddr;
                s_arid    = rgnt ? m1_arid    : m0_arid;
                s_arlen   = rgnt ? m1_arlen   : m0_arlen;
                s_arsize  = rgnt ? m1_arsize  : m0_arsize;
                s_arburst = rgnt ? m1_arburst : m0_arburst;
                if (rgnt) m1_arready = s_arready;
                else      m0_arready = s_arready;
                if (!sel_arvalid)   rd_state_nxt = R_IDLE;
                else if (s_arready) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_rready = sel_rready;
                if (rgnt) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rid    = s_rid;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rid    = s_rid;
                end
                if (s_rvalid && sel_rready && s_rlast) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Write-path state, grant and round-robin pointer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wgnt     <= 1'b0;
            wr_rr    <= 1'b1;
        end else begin
            wr_state <= wr_state_nxt;
            wgnt     <= wgnt_nxt;
            wr_rr    <= wr_rr_nxt;
        end
    end

    // Write-path arbitration, next state and AW/W/B channel routing
    always_comb begin
        wr_state_nxt = wr_state;
        wgnt_nxt     = wgnt;
        wr_rr_nxt    = wr_rr;
        s_awvalid    = '0;
        s_awaddr     = '0;
        s_awid       = '0;
        s_awlen      = '0;
        s_awsize     = '0;
        s_awburst    = '0;
        s_wvalid     = '0;
        s_wdata      = '0;
        s_wstrb      = '0;
        s_wlast      = '0;
        s_bready     = '0;
        m0_awready   = '0;
        m1_awready   = '0;
        m0_wready    = '0;
        m1_wready    = '0;
        m0_bvalid    = '0;
        m0_bresp     = '0;
        m0_bid       = '0;
        m1_bvalid    = '0;
        m1_bresp     = '0;
        m1_bid       = '0;
        case (wr_state)
            W_IDLE: begin
                if (m0_awvalid && m1_awvalid) begin
                    wgnt_nxt     = ~wr_rr;
                    wr_rr_nxt    = ~wr_rr;
                    wr_state_nxt = W_ADDR;
                end else if (m0_awvalid || m1_awvalid) begin
                    wgnt_nxt     = m1_awvalid;
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                s_awvalid = sel_awvalid;
                s_awaddr  = wgnt ? m1_awaddr  : m0_awaddr;
                s_awid    = wgnt ? m1_awid    : m0_awid;
                s_awlen   = wgnt ? m1_awlen   : m0_awlen;
                s_awsize  = wgnt ? m1_awsize  : m0_awsize;
                s_awburst = wgnt ? m1_awburst : m0_awburst;
                if (wgnt) m1_awready = s_awready;
                else      m0_awready = s_awready;
                if (!sel_awvalid)   wr_state_nxt = W_IDLE;
                else if (s_awready) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_wvalid = sel_wvalid;
                s_wdata  = wgnt ? m1_wdata : m0_wdata;
                s_wstrb  = wgnt ? m1_wstrb : m0_wstrb;
                s_wlast  = sel_wlast;
                if (wgnt) m1_wready = s_wready;
                else      m0_wready = s_wready;
                if (sel_wvalid && s_wready && sel_wlast) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_bready = sel_bready;
                if (wgnt) begin
                    m1_bvalid = s_bvalid;
                    m1_bresp  = s_bresp;
                    m1_bid    = s_bid;
                end else begin
                    m0_bvalid = s_bvalid;
                    m0_bresp  = s_bresp;
                    m0_bid    = s_bid;
                end
                if (s_bvalid && sel_bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed and randomized checks of axi_mem_arbiter against a transaction-level model.
module tb_axi_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [3:0]  m0_rid, m1_rid;
    logic        m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid, m0_wlast, m1_wlast;
    logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    logic [3:0]  m0_awid, m1_awid, m0_wstrb, m1_wstrb;
    logic [7:0]  m0_awlen, m1_awlen;
    logic [2:0]  m0_awsize, m1_awsize;
    logic [1:0]  m0_awburst, m1_awburst;
    logic        m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
    logic        m0_bready, m1_bready;
    logic [1:0]  m0_bresp, m1_bresp;
    logic [3:0]  m0_bid, m1_bid;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awid, s_wstrb, s_bid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic        rd_busy, wr_busy;

    int n_asserts = 0;
    int n_fail    = 0;
    // model: which master won the most recent tie on each path (1 after reset so m0 wins first)
    int rd_last_tie = 1;
    int wr_last_tie = 1;

    axi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rid(m0_rid), .m0_rready(m0_rready),
        .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
        .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
        .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
        .m0_bready(m0_bready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rid(m1_rid), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
        .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_bready(s_bready),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rdat(input logic [31:0] a, input int b);
        return a ^ (32'h5a5a_0000 + 32'(b) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] wdat(input logic [31:0] a, input int b);
        return a ^ (32'h9e37_79b9 * 32'(b + 1));
    endfunction

    task automatic set_ar(input int m, input logic v, input logic [31:0] a, input logic [7:0] l,
                          input logic [3:0] id);
        if (m == 0) begin
            m0_arvalid = v; m0_araddr = a; m0_arlen = l; m0_arid = id; m0_arsize = 3'd2; m0_arburst = 2'd1;
        end else begin
            m1_arvalid = v; m1_araddr = a; m1_arlen = l; m1_arid = id; m1_arsize = 3'd3; m1_arburst = 2'd2;
        end
    endtask

    task automatic set_aw(input int m, input logic v, input logic [31:0] a, input logic [7:0] l,
                          input logic [3:0] id);
        if (m == 0) begin
            m0_awvalid = v; m0_awaddr = a; m0_awlen = l; m0_awid = id; m0_awsize = 3'd2; m0_awburst = 2'd1;
        end else begin
            m1_awvalid = v; m1_awaddr = a; m1_awlen = l; m1_awid = id; m1_awsize = 3'd3; m1_awburst = 2'd2;
        end
    endtask

    task automatic set_w(input int m, input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic l);
        if (m == 0) begin m0_wvalid = v; m0_wdata = d; m0_wstrb = s; m0_wlast = l; end
        else        begin m1_wvalid = v; m1_wdata = d; m1_wstrb = s; m1_wlast = l; end
    endtask

    task automatic do_reset();
        set_ar(0, 0, '0, '0, '0); set_ar(1, 0, '0, '0, '0);
        set_aw(0, 0, '0, '0, '0); set_aw(1, 0, '0, '0, '0);
        set_w(0, 0, '0, '0, 0);   set_w(1, 0, '0, '0, 0);
        m0_rready = 0; m1_rready = 0; m0_bready = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
        reset = 1;
        tick(); tick();
        reset = 0;
        rd_last_tie = 1;
        wr_last_tie = 1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid,
                            m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
                            s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, rd_busy, wr_busy}, '0);
        chk({tag, "_data"}, 64'(|{m0_rdata, m0_rresp, m0_rlast, m0_rid, m0_bresp, m0_bid,
                                  m1_rdata, m1_rresp, m1_rlast, m1_rid, m1_bresp, m1_bid,
                                  s_araddr, s_arid, s_arlen, s_arsize, s_arburst,
                                  s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
                                  s_wdata, s_wstrb, s_wlast}), '0);
    endtask

    // Slave side of one read burst expected to belong to master m; rnd throttles the handshakes.
    task automatic serve_read(input int m, input logic [31:0] addr, input logic [7:0] len,
                              input logic [3:0] id, input bit rnd);
        bit          ok;
        int          b;
        logic [31:0] d;
        logic [1:0]  rsp;
        logic        mrr;
        ok = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            s_arready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (s_arvalid && s_arready) begin
                chk("ar_addr", s_araddr, addr);
                chk("ar_len", s_arlen, len);
                chk("ar_id", s_arid, id);
                chk("ar_size_burst", {s_arsize, s_arburst}, (m != 0) ? 5'b011_10 : 5'b010_01);
                chk("ar_ready_gnt", (m != 0) ? m1_arready : m0_arready, 1);
                chk("ar_ready_other", (m != 0) ? m0_arready : m1_arready, 0);
                ok = 1;
            end
            tick();
        end
        chk("ar_handshake_seen", ok, 1);
        s_arready = 0;
        set_ar(m, 0, addr, len, id);
        b = 0;
        for (int c = 0; c < 200 && b <= int'(len); c++) begin
            d   = rdat(addr, b);
            rsp = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
            s_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_rdata = d; s_rresp = rsp; s_rlast = (b == int'(len)); s_rid = id;
            mrr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m != 0) begin m1_rready = mrr; m0_rready = ($urandom_range(0, 1) != 0); end
            else        begin m0_rready = mrr; m1_rready = ($urandom_range(0, 1) != 0); end
            #1;
            chk("r_valid", (m != 0) ? m1_rvalid : m0_rvalid, s_rvalid);
            chk("r_valid_other", (m != 0) ? m0_rvalid : m1_rvalid, 0);
            chk("r_ready", s_rready, mrr);
            if (s_rvalid && mrr) begin
                chk("r_data", (m != 0) ? m1_rdata : m0_rdata, d);
                chk("r_resp_last_id", (m != 0) ? {m1_rresp, m1_rlast, m1_rid} : {m0_rresp, m0_rlast, m0_rid},
                    {rsp, (b == int'(len)), id});
                chk("r_data_other", (m != 0) ? m0_rdata : m1_rdata, 0);
                b++;
            end
            tick();
        end
        chk("r_beats", b, int'(len) + 1);
        s_rvalid = 0; s_rlast = 0; m0_rready = 0; m1_rready = 0;
        #1;
        chk("r_idle_after_last", rd_busy, 0);
    endtask

    // Master m's W/B traffic plus slave side of one write burst expected to belong to m.
    task automatic serve_write(input int m, input logic [31:0] addr, input logic [7:0] len,
                               input logic [3:0] id, input bit rnd);
        bit         ok;
        int         b;
        logic       wv, bv, mbr;
        logic [3:0] st;
        logic [1:0] rsp;
        ok = 0;
        set_w(m, 1, wdat(addr, 0), 4'hf, len == 0);
        s_wready = 1;
        for (int c = 0; c < 40 && !ok; c++) begin
            s_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            chk("w_held_before_aw", s_wvalid, 0);
            chk("wready_before_aw", (m != 0) ? m1_wready : m0_wready, 0);
            if (s_awvalid && s_awready) begin
                chk("aw_addr", s_awaddr, addr);
                chk("aw_len_id", {s_awlen, s_awid}, {len, id});
                chk("aw_size_burst", {s_awsize, s_awburst}, (m != 0) ? 5'b011_10 : 5'b010_01);
                chk("aw_ready_gnt", (m != 0) ? m1_awready : m0_awready, 1);
                chk("aw_ready_other", (m != 0) ? m0_awready : m1_awready, 0);
                ok = 1;
            end
            tick();
        end
        chk("aw_handshake_seen", ok, 1);
        s_awready = 0;
        set_aw(m, 0, addr, len, id);
        b = 0;
        for (int c = 0; c < 200 && b <= int'(len); c++) begin
            wv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            st = 4'(b) ^ 4'ha;
            set_w(m, wv, wdat(addr, b), st, b == int'(len));
            s_wready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("w_valid", s_wvalid, wv);
            chk("w_ready", (m != 0) ? m1_wready : m0_wready, s_wready);
            chk("w_ready_other", (m != 0) ? m0_wready : m1_wready, 0);
            if (wv && s_wready) begin
                chk("w_data", s_wdata, wdat(addr, b));
                chk("w_strb_last", {s_wstrb, s_wlast}, {st, (b == int'(len))});
                b++;
            end
            tick();
        end
        chk("w_beats", b, int'(len) + 1);
        set_w(m, 0, '0, '0, 0);
        s_wready = 0;
        ok = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            bv  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            rsp = 2'($urandom_range(0, 3));
            mbr = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_bvalid = bv; s_bresp = rsp; s_bid = id;
            if (m != 0) m1_bready = mbr; else m0_bready = mbr;
            #1;
            chk("b_valid", (m != 0) ? m1_bvalid : m0_bvalid, bv);
            chk("b_valid_other", (m != 0) ? m0_bvalid : m1_bvalid, 0);
            chk("b_ready", s_bready, mbr);
            if (bv && mbr) begin
                chk("b_resp_id", (m != 0) ? {m1_bresp, m1_bid} : {m0_bresp, m0_bid}, {rsp, id});
                ok = 1;
            end
            tick();
        end
        chk("b_handshake_seen", ok, 1);
        s_bvalid = 0; m0_bready = 0; m1_bready = 0;
        #1;
        chk("w_idle_after_b", wr_busy, 0);
    endtask

    initial begin
        int          pat, first;
        logic [31:0] a0, a1;
        logic [7:0]  l0, l1;
        logic [3:0]  i0, i1;

        // reset state
        do_reset();
        #1;
        chk_quiet("reset");

        // m0 read alone: s_arvalid one cycle after request, four beats to m0 only
        set_ar(0, 1, 32'h3000_0010, 8'd3, 4'h5);
        s_arready = 1;
        #1;
        chk("t1_no_ar_in_idle", {s_arvalid, m0_arready}, 2'b00);
        tick();
        chk("t1_ar_latency", s_arvalid, 1);
        serve_read(0, 32'h3000_0010, 8'd3, 4'h5, 0);

        // tie after reset: m0 first, then m1; a second tie goes to m1
        set_ar(0, 1, 32'h1000_0000, 8'd1, 4'h1);
        set_ar(1, 1, 32'h2000_0000, 8'd0, 4'h2);
        serve_read(0, 32'h1000_0000, 8'd1, 4'h1, 0);
        chk("t2_bubble", s_arvalid, 0);
        serve_read(1, 32'h2000_0000, 8'd0, 4'h2, 0);
        set_ar(0, 1, 32'h1000_0040, 8'd0, 4'h3);
        set_ar(1, 1, 32'h2000_0040, 8'd2, 4'h4);
        serve_read(1, 32'h2000_0040, 8'd2, 4'h4, 0);
        serve_read(0, 32'h1000_0040, 8'd0, 4'h3, 0);

        // m0 withdraws before AR handshake; waiting m1 is granted next
        set_ar(0, 1, 32'h4000_0000, 8'd1, 4'h6);
        s_arready = 0;
        tick();
        set_ar(1, 1, 32'h5000_0000, 8'd1, 4'h7);
        #1;
        chk("t4_m0_pending", {s_arvalid, s_araddr}, {1'b1, 32'h4000_0000});
        tick();
        set_ar(0, 0, 32'h4000_0000, 8'd1, 4'h6);
        #1;
        chk("t4_no_ar_after_drop", s_arvalid, 0);
        tick();
        chk("t4_back_to_idle", {rd_busy, s_arvalid}, 2'b00);
        tick();
        chk("t4_m1_granted", {s_arvalid, s_araddr}, {1'b1, 32'h5000_0000});
        serve_read(1, 32'h5000_0000, 8'd1, 4'h7, 0);

        // m1 single-beat write in parallel with an m0 four-beat read
        set_ar(0, 1, 32'h3000_0100, 8'd3, 4'h2);
        set_aw(1, 1, 32'ha000_0100, 8'd0, 4'h7);
        set_w(1, 1, 32'hdead_beef, 4'hf, 1);
        s_arready = 1; s_awready = 0; s_wready = 1;
        #1;
        chk("t3_w_held_idle", s_wvalid, 0);
        tick();
        chk("t3_addr_phase", {s_arvalid, s_awvalid, s_wvalid, m1_wready}, 4'b1100);
        tick();
        set_ar(0, 0, 32'h3000_0100, 8'd3, 4'h2);
        s_arready = 0;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1; s_rdata = rdat(32'h3000_0100, b); s_rlast = (b == 3); s_rid = 4'h2; m0_rready = 1;
            case (b)
                0: s_awready = 1;
                1: begin s_awready = 0; set_aw(1, 0, 32'ha000_0100, 8'd0, 4'h7); end
                2: begin set_w(1, 0, '0, '0, 0); s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'h7; m1_bready = 1; end
                default: begin s_bvalid = 0; m1_bready = 0; end
            endcase
            #1;
            chk("t3_r_beat", {m0_rvalid, m0_rdata, m1_rvalid}, {1'b1, rdat(32'h3000_0100, b), 1'b0});
            case (b)
                0: chk("t3_aw", {s_awvalid, s_awaddr, s_wvalid}, {1'b1, 32'ha000_0100, 1'b0});
                1: chk("t3_w", {s_wvalid, s_wdata, s_wstrb, s_wlast, m1_wready}, {1'b1, 32'hdead_beef, 4'hf, 1'b1, 1'b1});
                2: chk("t3_b", {m1_bvalid, m1_bresp, s_bready}, {1'b1, 2'b00, 1'b1});
                default: chk("t3_wr_done", wr_busy, 0);
            endcase
            tick();
        end
        s_rvalid = 0; s_rlast = 0; m0_rready = 0;
        #1;
        chk("t3_rd_done", rd_busy, 0);

        // reset during R_DATA after the first of four beats
        set_ar(0, 1, 32'h3000_0200, 8'd3, 4'h9);
        s_arready = 1;
        tick(); tick();
        set_ar(0, 0, 32'h3000_0200, 8'd3, 4'h9);
        s_arready = 0;
        s_rvalid = 1; s_rdata = 32'h1234_5678; s_rlast = 0; s_rid = 4'h9; m0_rready = 1;
        #1;
        chk("t5_beat1", {m0_rvalid, m0_rdata}, {1'b1, 32'h1234_5678});
        tick();
        reset = 1;
        tick();
        reset = 0;
        rd_last_tie = 1;
        wr_last_tie = 1;
        #1;
        chk_quiet("t5_after_reset");
        s_rvalid = 0; m0_rready = 0;
        set_ar(1, 1, 32'h6000_0000, 8'd0, 4'ha);
        #1;
        chk("t5_no_same_cycle_ar", s_arvalid, 0);
        tick();
        chk("t5_m1_one_cycle", {s_arvalid, s_araddr}, {1'b1, 32'h6000_0000});
        serve_read(1, 32'h6000_0000, 8'd0, 4'ha, 0);

        // SLVERR on a single m1 beat held by m1_rready=0 for two cycles
        set_ar(1, 1, 32'h7000_0000, 8'd0, 4'hb);
        s_arready = 1;
        tick(); tick();
        set_ar(1, 0, 32'h7000_0000, 8'd0, 4'hb);
        s_arready = 0;
        s_rvalid = 1; s_rdata = 32'hcafe_f00d; s_rresp = 2'b10; s_rlast = 1; s_rid = 4'hb; m1_rready = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("t6_held", {m1_rvalid, m1_rresp, s_rready, rd_busy}, {1'b1, 2'b10, 1'b0, 1'b1});
            tick();
        end
        m1_rready = 1;
        #1;
        chk("t6_deliver", {m1_rvalid, m1_rdata, m1_rresp, m1_rlast, s_rready}, {1'b1, 32'hcafe_f00d, 2'b10, 1'b1, 1'b1});
        tick();
        s_rvalid = 0; s_rlast = 0; s_rresp = 0; m1_rready = 0;
        #1;
        chk("t6_idle", rd_busy, 0);

        // randomized read traffic; tie winners alternate starting with m0
        do_reset();
        for (int it = 0; it < 24; it++) begin
            pat = $urandom_range(1, 3);
            a0 = $urandom; a1 = $urandom;
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            i0 = 4'($urandom); i1 = 4'($urandom);
            if (pat != 2) set_ar(0, 1, a0, l0, i0);
            if (pat != 1) set_ar(1, 1, a1, l1, i1);
            if (pat == 3) begin
                first = 1 - rd_last_tie;
                rd_last_tie = first;
            end else begin
                first = (pat == 2) ? 1 : 0;
            end
            if (first == 0) serve_read(0, a0, l0, i0, 1);
            else            serve_read(1, a1, l1, i1, 1);
            if (pat == 3) begin
                if (first == 0) serve_read(1, a1, l1, i1, 1);
                else            serve_read(0, a0, l0, i0, 1);
            end
        end

        // randomized write traffic with the same fairness rule
        for (int it = 0; it < 24; it++) begin
            pat = $urandom_range(1, 3);
            a0 = $urandom; a1 = $urandom;
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            i0 = 4'($urandom); i1 = 4'($urandom);
            if (pat != 2) set_aw(0, 1, a0, l0, i0);
            if (pat != 1) set_aw(1, 1, a1, l1, i1);
            if (pat == 3) begin
                first = 1 - wr_last_tie;
                wr_last_tie = first;
            end else begin
                first = (pat == 2) ? 1 : 0;
            end
            if (first == 0) serve_write(0, a0, l0, i0, 1);
            else            serve_write(1, a1, l1, i1, 1);
            if (pat == 3) begin
                if (first == 0) serve_write(1, a1, l1, i1, 1);
                else            serve_write(0, a0, l0, i0, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
